// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_pkg: shared encodings and helpers for the load/store unit      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   function automatic logic [2:0] size_bytes(input logic [1:0] size_code);
      case (size_code)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   function automatic logic f3_illegal(input logic [2:0] f3);
      f3_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_byte_lane: byte merge (store) and extract/extend (load) for    |
// | one memory word of a possibly split access.  Revision: 1.0         |
// +--------------------------------------------------------------------+
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_rd,
   input  logic [31:0] wdata,
   input  logic [31:0] acc_in,
   input  logic [1:0]  offset,
   input  logic [1:0]  size_code,
   input  logic        part,
   input  logic        unsigned_ld,
   output logic [31:0] st_word,
   output logic [31:0] ld_raw,
   output logic [31:0] ld_ext
);

   logic [2:0] w_nbytes;

   assign w_nbytes = size_bytes(size_code);

   always_comb begin
      st_word = word_rd;
      ld_raw  = acc_in;
      ld_ext  = '0;
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < 4; k++) begin
            // lane j of this word holds access byte k (part 1 continues at lane 0)
            if (((j + (part ? 4 : 0)) == (k + int'(offset))) && (k < int'(w_nbytes))) begin
               st_word[8*j +: 8] = wdata[8*k +: 8];
               ld_raw[8*k +: 8]  = word_rd[8*j +: 8];
            end
         end
      end
      case (size_code)
         SZ_BYTE: ld_ext = unsigned_ld ? {24'b0, ld_raw[7:0]}  : {{24{ld_raw[7]}}, ld_raw[7:0]};
         SZ_HALF: ld_ext = unsigned_ld ? {16'b0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit: RV32I byte/half/word load-store unit with         |
// | misaligned split access and range checking.  Revision: 1.0         |
// +--------------------------------------------------------------------+
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int AW        = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   lsu_state_e    state_q, state_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [2:0]    funct3_q, funct3_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;

   logic [2:0]    w_req_size;
   logic          w_req_split;
   logic [AW:0]   w_req_last;
   logic          w_req_err;
   logic [2:0]    w_size;
   logic          w_split;
   logic [AW-1:0] w_word0;
   logic [AW-1:0] w_word1;
   logic          w_part;
   logic [31:0]   w_acc_in;
   logic [31:0]   w_st_word;
   logic [31:0]   w_ld_raw;
   logic [31:0]   w_ld_ext;

   // Errors are resolved at acceptance so a bad request never touches memory
   assign w_req_size  = size_bytes(req_funct3[1:0]);
   assign w_req_split = ({1'b0, req_addr[1:0]} + w_req_size) > 3'd4;
   assign w_req_last  = {1'b0, req_addr[AW+1:2]} + {{AW{1'b0}}, w_req_split};
   assign w_req_err   = f3_illegal(req_funct3) || (|req_addr[31:AW+2]) ||
                        (w_req_last >= (AW+1)'(MEM_WORDS));

   assign w_size   = size_bytes(funct3_q[1:0]);
   assign w_split  = ({1'b0, addr_q[1:0]} + w_size) > 3'd4;
   assign w_word0  = addr_q[AW+1:2];
   assign w_word1  = w_word0 + AW'(1);
   assign w_part   = (state_q == ACC1);
   assign w_acc_in = w_part ? rdata_q : '0;

   lsu_byte_lane u_byte_lane (
      .word_rd     (mem_rd),
      .wdata       (wdata_q),
      .acc_in      (w_acc_in),
      .offset      (addr_q[1:0]),
      .size_code   (funct3_q[1:0]),
      .part        (w_part),
      .unsigned_ld (funct3_q[2]),
      .st_word     (w_st_word),
      .ld_raw      (w_ld_raw),
      .ld_ext      (w_ld_ext)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      funct3_d   = funct3_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;
      mem_a      = '0;
      mem_wd     = '0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d   = req_addr[AW+1:0];
               funct3_d = req_funct3;
               we_d     = req_we;
               wdata_d  = req_wdata;
               rdata_d  = '0;
               err_d    = w_req_err;
               state_d  = w_req_err ? RESP : ACC0;
            end
         end
         ACC0, ACC1: begin
            mem_a  = {{(32-AW){1'b0}}, (w_part ? w_word1 : w_word0)};
            mem_we = we_q;
            mem_wd = we_q ? w_st_word : '0;
            // First half of a split load is kept raw; extension waits for all bytes
            if ((state_q == ACC0) && w_split) begin
               rdata_d = we_q ? '0 : w_ld_raw;
               state_d = ACC1;
            end else begin
               rdata_d = we_q ? '0 : w_ld_ext;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_load_store_unit: scoreboard bench for load_store_unit           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          passes = 0;

   logic [31:0] dm [0:1023];
   logic [31:0] mm [0:1023];
   logic        poke_en = 1'b0;
   logic [9:0]  poke_a = 10'd0;
   logic [31:0] poke_d = 32'd0;
   int          we_cnt = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(1024), .AW(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   assign mem_rd = (mem_a[31:10] == 22'd0) ? dm[mem_a[9:0]] : 32'hDEADDEAD;

   always @(posedge clk) begin
      if (poke_en) dm[poke_a] <= poke_d;
      else if (mem_we) dm[mem_a[9:0]] <= mem_wd;
      if (mem_we) we_cnt <= we_cnt + 1;
   end

   task automatic poke(input int w, input logic [31:0] d);
      poke_en = 1'b1; poke_a = w[9:0]; poke_d = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
      mm[w] = d;
   endtask

   task automatic send_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
      int n;
      n = 0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin
         checks++;
         $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic get_resp(output logic [31:0] rd, output logic err, output int lat);
      lat = 1;
      while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      rd = resp_rdata; err = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   // Byte-addressed reference: walks each touched byte independently
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output exp_t e);
      int          sz;
      longint      ba;
      int          w, sh;
      logic [31:0] v;
      logic [7:0]  b;
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      e.err   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
                ((longint'(addr) + sz - 1) > 4095);
      e.rdata = 32'd0;
      e.lat   = e.err ? 1 : ((int'(addr % 4) + sz > 4) ? 3 : 2);
      v = 32'd0;
      if (!e.err) begin
         for (int i = 0; i < sz; i++) begin
            ba = longint'(addr) + i;
            w  = int'(ba / 4);
            sh = 8 * int'(ba % 4);
            if (we) begin
               b = 8'((wd >> (8 * i)) & 32'hFF);
               mm[w] = (mm[w] & ~(32'hFF << sh)) | ({24'd0, b} << sh);
            end else begin
               b = 8'((mm[w] >> sh) & 32'hFF);
               v = v | ({24'd0, b} << (8 * i));
            end
         end
         if (!we) begin
            if (sz == 1)      e.rdata = f3[2] ? v : {{24{v[7]}}, v[7:0]};
            else if (sz == 2) e.rdata = f3[2] ? v : {{16{v[15]}}, v[15:0]};
            else              e.rdata = v;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else passes++;
      checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else passes++;
      checks++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err: got %b want 0", resp_err); else passes++;
      checks++; if (resp_rdata !== 32'd0) $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); else passes++;
      checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else passes++;
      checks++; if (mem_a !== 32'd0) $display("FAIL rst_mem_a: got %h want 0", mem_a); else passes++;
      checks++; if (mem_wd !== 32'd0) $display("FAIL rst_mem_wd: got %h want 0", mem_wd); else passes++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_lw();
      logic [31:0] rd; logic err; int lat; exp_t e;
      poke(28, 32'h00000020);
      sb_q.push_back('{rdata: 32'h00000020, err: 1'b0, lat: 2});
      send_req(1'b0, 3'd2, 32'h70, 32'd0);
      get_resp(rd, err, lat);
      e = sb_q.pop_front();
      checks++; if (rd !== e.rdata) $display("FAIL lw_rdata: got %h want %h", rd, e.rdata); else passes++;
      checks++; if (err !== e.err) $display("FAIL lw_err: got %b want %b", err, e.err); else passes++;
      checks++; if (lat !== e.lat) $display("FAIL lw_latency: got %0d want %0d", lat, e.lat); else passes++;
   endtask

   task automatic test_sb();
      logic [31:0] rd; logic err; int lat; exp_t e; int w0;
      poke(28, 32'h11223344);
      w0 = we_cnt;
      sb_q.push_back('{rdata: 32'd0, err: 1'b0, lat: 2});
      send_req(1'b1, 3'd0, 32'h71, 32'hFFFFFFA5);
      get_resp(rd, err, lat);
      e = sb_q.pop_front();
      checks++; if (rd !== e.rdata) $display("FAIL sb_rdata: got %h want %h", rd, e.rdata); else passes++;
      checks++; if (err !== e.err) $display("FAIL sb_err: got %b want %b", err, e.err); else passes++;
      checks++; if (lat !== e.lat) $display("FAIL sb_latency: got %0d want %0d", lat, e.lat); else passes++;
      checks++; if (dm[28] !== 32'h1122A544) $display("FAIL sb_mem: got %h want 1122a544", dm[28]); else passes++;
      checks++; if (we_cnt - w0 !== 1) $display("FAIL sb_we_pulses: got %0d want 1", we_cnt - w0); else passes++;
   endtask

   task automatic test_split_lh();
      logic [31:0] rd; logic err; int lat; exp_t e;
      poke(28, 32'h80000000);
      poke(29, 32'h000000FF);
      sb_q.push_back('{rdata: 32'hFFFFFF80, err: 1'b0, lat: 3});
      send_req(1'b0, 3'd1, 32'h73, 32'd0);
      get_resp(rd, err, lat);
      e = sb_q.pop_front();
      checks++; if (rd !== e.rdata) $display("FAIL lh_split_rdata: got %h want %h", rd, e.rdata); else passes++;
      checks++; if (err !== e.err) $display("FAIL lh_split_err: got %b want %b", err, e.err); else passes++;
      checks++; if (lat !== e.lat) $display("FAIL lh_split_latency: got %0d want %0d", lat, e.lat); else passes++;
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic err; int lat; exp_t e; int w0;
      logic        ew [4];
      logic [2:0]  ef [4];
      logic [31:0] ea [4];
      ew = '{1'b1, 1'b0, 1'b0, 1'b0};
      ef = '{3'd2, 3'd2, 3'd3, 3'd1};
      ea = '{32'hFFD, 32'h1000, 32'h70, 32'hFFE};
      poke(1023, 32'h7FFF0000);
      w0 = we_cnt;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) sb_q.push_back('{rdata: 32'd0, err: 1'b1, lat: 1});
         else       sb_q.push_back('{rdata: 32'h00007FFF, err: 1'b0, lat: 2});
         send_req(ew[i], ef[i], ea[i], 32'hCAFEF00D);
         get_resp(rd, err, lat);
         e = sb_q.pop_front();
         checks++; if (rd !== e.rdata) $display("FAIL range_rdata[%0d]: got %h want %h", i, rd, e.rdata); else passes++;
         checks++; if (err !== e.err) $display("FAIL range_err[%0d]: got %b want %b", i, err, e.err); else passes++;
         checks++; if (lat !== e.lat) $display("FAIL range_latency[%0d]: got %0d want %0d", i, lat, e.lat); else passes++;
      end
      checks++; if (we_cnt - w0 !== 0) $display("FAIL range_we_pulses: got %0d want 0", we_cnt - w0); else passes++;
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic err; int lat; exp_t e; logic stable;
      poke(28, 32'h1122A544);
      sb_q.push_back('{rdata: 32'h1122A544, err: 1'b0, lat: 2});
      send_req(1'b0, 3'd2, 32'h70, 32'd0);
      lat = 1;
      while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      e = sb_q.pop_front();
      checks++; if (lat !== e.lat) $display("FAIL bp_latency: got %0d want %0d", lat, e.lat); else passes++;
      // next request presented while busy must be ignored until IDLE
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd4; req_addr = 32'h71;
      stable = 1'b1;
      repeat (5) begin
         if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || req_ready !== 1'b0) stable = 1'b0;
         @(posedge clk); #1;
      end
      checks++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b want 1 (rdata %h)", stable, resp_rdata); else passes++;
      checks++; if (resp_rdata !== e.rdata) $display("FAIL bp_rdata: got %h want %h", resp_rdata, e.rdata); else passes++;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_after_hs: got %b want 1", req_ready); else passes++;
      sb_q.push_back('{rdata: 32'h000000A5, err: 1'b0, lat: 2});
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (req_ready !== 1'b0) $display("FAIL bp_accept: req_ready got %b want 0", req_ready); else passes++;
      get_resp(rd, err, lat);
      e = sb_q.pop_front();
      checks++; if (rd !== e.rdata) $display("FAIL bp_next_rdata: got %h want %h", rd, e.rdata); else passes++;
      checks++; if (lat !== e.lat) $display("FAIL bp_next_latency: got %0d want %0d", lat, e.lat); else passes++;
   endtask

   task automatic test_reset_abort();
      poke(40, 32'h01020304);
      poke(41, 32'h05060708);
      send_req(1'b1, 3'd2, 32'hA2, 32'hDEADBEEF);
      checks++; if (mem_we !== 1'b1) $display("FAIL abort_acc0_we: got %b want 1", mem_we); else passes++;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) $display("FAIL abort_idle: req_ready got %b want 1", req_ready); else passes++;
      checks++; if (mem_we !== 1'b0) $display("FAIL abort_mem_we: got %b want 0", mem_we); else passes++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (dm[40] !== 32'hBEEF0304) $display("FAIL abort_word0: got %h want beef0304", dm[40]); else passes++;
      checks++; if (dm[41] !== 32'h05060708) $display("FAIL abort_word1: got %h want 05060708", dm[41]); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic err; int lat; exp_t e; exp_t m;
      logic we; logic [2:0] f3; logic [31:0] addr, wd;
      logic [2:0] ld_f3 [7];
      logic       mem_ok;
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
      for (int w = 200; w <= 204; w++) poke(w, $urandom);
      for (int i = 0; i < 40; i++) begin
         we   = 1'($urandom_range(0, 1));
         f3   = we ? 3'($urandom_range(0, 3)) : ld_f3[$urandom_range(0, 6)];
         addr = 32'd800 + 32'($urandom_range(0, 15));
         wd   = $urandom;
         model(we, f3, addr, wd, m);
         sb_q.push_back(m);
         send_req(we, f3, addr, wd);
         get_resp(rd, err, lat);
         e = sb_q.pop_front();
         checks++; if (rd !== e.rdata) $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rd, e.rdata); else passes++;
         checks++; if (err !== e.err) $display("FAIL b2b_err[%0d]: got %b want %b", i, err, e.err); else passes++;
         checks++; if (lat !== e.lat) $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, e.lat); else passes++;
      end
      mem_ok = 1'b1;
      for (int w = 200; w <= 204; w++) if (dm[w] !== mm[w]) mem_ok = 1'b0;
      checks++; if (mem_ok !== 1'b1) $display("FAIL b2b_mem: got %h want %h (word 203)", dm[203], mm[203]); else passes++;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sb();
      test_split_lh();
      test_errors();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
